// File: rtl/cmp_pkg.sv
// Shared types and helpers for the iterative comparator (cmp_iter) and its chunk compare.
package cmp_pkg;

  typedef enum logic [1:0] {
    IDLE,
    BUSY,
    DONE
  } state_t;

  typedef struct packed {
    logic eq;
    logic gt;
    logic lt;
  } res_t;

  // Bit offset of chunk 'idx' when the operand is cut into 'width'-bit chunks.
  function automatic int unsigned chunk_lsb(input int unsigned idx, input int unsigned width);
    return idx * width;
  endfunction

endpackage

// File: rtl/cmp.sv
// Combinational unsigned magnitude comparator, used by cmp_iter for one chunk per cycle.
module cmp #(
  parameter int unsigned W = 16
) (
  input  logic [W-1:0] i_a,
  input  logic [W-1:0] i_b,
  output logic         o_eq,
  output logic         o_gt,
  output logic         o_lt
);

  assign o_eq = (i_a == i_b);
  assign o_gt = (i_a > i_b);
  assign o_lt = (i_a < i_b);

endmodule

// File: rtl/cmp_iter.sv
// Iterative MSB-first chunked magnitude comparator with valid/ready request and result ports.
// Optional CMP_ITER_EARLY_EXIT_EN: stop on the first differing chunk instead of scanning all N.
module cmp_iter
  import cmp_pkg::*;
#(
  parameter int unsigned W = 64,
  parameter int unsigned C = 16
) (
  input  logic         clk,
  input  logic         arst,
  input  logic         i_vld,
  input  logic [W-1:0] i_a,
  input  logic [W-1:0] i_b,
  input  logic         i_signed,
  output logic         o_rdy,
  output logic         o_res_vld,
  input  logic         i_res_rdy,
  output logic         o_eq,
  output logic         o_gt,
  output logic         o_lt
);

  localparam int unsigned N  = W / C;
  localparam int unsigned CW = (N > 1) ? $clog2(N) : 1;

  if ((W % C) != 0 || C > W) begin : g_bad_cfg
    $error("cmp_iter: W must be a non-zero multiple of C and C must not exceed W");
  end

  state_t         state_q, state_d;
  logic [CW-1:0]  cnt_q;
  logic [W-1:0]   a_q, b_q;
  logic [W-1:0]   flip;
  logic [C-1:0]   a_chunk, b_chunk;
  logic           chunk_eq, chunk_gt, chunk_lt_unused;
  logic           last_beat;
  res_t           res_q;

`ifndef CMP_ITER_EARLY_EXIT_EN
  logic           dec_q;
  logic           dec_gt_q;
`endif

  // Flipping the sign bit of both operands maps two's-complement order onto unsigned order.
  always_comb begin
    flip        = '0;
    flip[W-1]   = i_signed;
    a_chunk     = C'(a_q >> chunk_lsb(32'(cnt_q), C));
    b_chunk     = C'(b_q >> chunk_lsb(32'(cnt_q), C));
    last_beat   = (cnt_q == '0);
  end

  cmp #(.W(C)) u_cmp (
    .i_a  (a_chunk),
    .i_b  (b_chunk),
    .o_eq (chunk_eq),
    .o_gt (chunk_gt),
    .o_lt (chunk_lt_unused)
  );

  always_ff @(posedge clk or posedge arst) begin
    if (arst) state_q <= IDLE;
    else      state_q <= state_d;
  end

  always_comb begin
    state_d   = state_q;
    o_rdy     = 1'b0;
    o_res_vld = 1'b0;
    case (state_q)
      IDLE: begin
        o_rdy = 1'b1;
        if (i_vld) state_d = BUSY;
      end
      BUSY: begin
`ifdef CMP_ITER_EARLY_EXIT_EN
        if (!chunk_eq || last_beat) state_d = DONE;
`else
        if (last_beat) state_d = DONE;
`endif
      end
      DONE: begin
        o_res_vld = 1'b1;
        if (i_res_rdy) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge arst) begin
    if (arst) begin
      a_q      <= '0;
      b_q      <= '0;
      cnt_q    <= '0;
      res_q    <= '0;
`ifndef CMP_ITER_EARLY_EXIT_EN
      dec_q    <= 1'b0;
      dec_gt_q <= 1'b0;
`endif
    end else begin
      case (state_q)
        IDLE: begin
          if (i_vld) begin
            a_q   <= i_a ^ flip;
            b_q   <= i_b ^ flip;
            cnt_q <= CW'(N - 1);
`ifndef CMP_ITER_EARLY_EXIT_EN
            dec_q <= 1'b0;
`endif
          end
        end
        BUSY: begin
`ifdef CMP_ITER_EARLY_EXIT_EN
          if (!chunk_eq)      res_q <= '{eq: 1'b0, gt: chunk_gt, lt: ~chunk_gt};
          else if (last_beat) res_q <= '{eq: 1'b1, gt: 1'b0, lt: 1'b0};
          else                cnt_q <= cnt_q - CW'(1);
`else
          // The most significant differing chunk wins; later chunks cannot overwrite it.
          if (!dec_q && !chunk_eq) begin
            dec_q    <= 1'b1;
            dec_gt_q <= chunk_gt;
          end
          if (last_beat) begin
            if (dec_q)          res_q <= '{eq: 1'b0, gt: dec_gt_q, lt: ~dec_gt_q};
            else if (!chunk_eq) res_q <= '{eq: 1'b0, gt: chunk_gt, lt: ~chunk_gt};
            else                res_q <= '{eq: 1'b1, gt: 1'b0, lt: 1'b0};
          end else begin
            cnt_q <= cnt_q - CW'(1);
          end
`endif
        end
        default: ;
      endcase
    end
  end

  assign o_eq = res_q.eq;
  assign o_gt = res_q.gt;
  assign o_lt = res_q.lt;

endmodule

// File: tb/tb_cmp_iter.sv
// Self-checking bench for cmp_iter (W=32, C=8): transaction-level model plus directed vectors.
module tb_cmp_iter;

  localparam int unsigned W = 32;
  localparam int unsigned C = 8;
  localparam int unsigned N = W / C;
`ifdef CMP_ITER_EARLY_EXIT_EN
  localparam bit EE = 1'b1;
`else
  localparam bit EE = 1'b0;
`endif

  logic         clk = 1'b0;
  logic         arst;
  logic         i_vld;
  logic [W-1:0] i_a, i_b;
  logic         i_signed;
  logic         o_rdy, o_res_vld, i_res_rdy;
  logic         o_eq, o_gt, o_lt;

  always #5 clk = ~clk;

  cmp_iter #(.W(W), .C(C)) dut (
    .clk       (clk),
    .arst      (arst),
    .i_vld     (i_vld),
    .i_a       (i_a),
    .i_b       (i_b),
    .i_signed  (i_signed),
    .o_rdy     (o_rdy),
    .o_res_vld (o_res_vld),
    .i_res_rdy (i_res_rdy),
    .o_eq      (o_eq),
    .o_gt      (o_gt),
    .o_lt      (o_lt)
  );

  int tests = 0;
  int fails = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference result as {eq, gt, lt}, straight from full-width arithmetic.
  function automatic logic [2:0] ref_res(input logic [W-1:0] a, input logic [W-1:0] b,
                                         input logic s);
    if (s) begin
      if ($signed(a) == $signed(b))     return 3'b100;
      else if ($signed(a) > $signed(b)) return 3'b010;
      else                              return 3'b001;
    end
    if (a == b)     return 3'b100;
    else if (a > b) return 3'b010;
    return 3'b001;
  endfunction

  function automatic int ref_lat(input logic [W-1:0] a, input logic [W-1:0] b);
    logic [W-1:0] d;
    d = a ^ b;
    if (!EE) return N;
    for (int i = 0; i < N; i++)
      if (d[(N-1-i)*C +: C] != '0) return i + 1;
    return N;
  endfunction

  // Transaction-level model: request accepted when idle, result after ref_lat cycles,
  // held until consumed; result value held while not valid.
  bit         m_busy = 1'b0;
  bit         m_vld  = 1'b0;
  int         m_left = 0;
  logic [2:0] m_res  = 3'b000;
  logic [2:0] m_next = 3'b000;

  always @(posedge clk or posedge arst) begin
    if (arst) begin
      m_busy <= 1'b0;
      m_vld  <= 1'b0;
      m_left <= 0;
      m_res  <= 3'b000;
    end else if (m_vld) begin
      if (i_res_rdy) m_vld <= 1'b0;
    end else if (m_busy) begin
      if (m_left == 1) begin
        m_busy <= 1'b0;
        m_vld  <= 1'b1;
        m_res  <= m_next;
      end
      m_left <= m_left - 1;
    end else if (i_vld) begin
      m_busy <= 1'b1;
      m_left <= ref_lat(i_a, i_b);
      m_next <= ref_res(i_a, i_b, i_signed);
    end
  end

  always @(negedge clk) begin
    check("o_rdy", o_rdy, !m_busy && !m_vld);
    check("o_res_vld", o_res_vld, m_vld);
    check("result", {o_eq, o_gt, o_lt}, m_res);
  end

  typedef struct {
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         s;
    logic [2:0]   res;
    int           lat_ee;
    int           lat_full;
    string        name;
  } vec_t;

  vec_t vecs[$];

  task automatic add_vec(input logic [W-1:0] a, input logic [W-1:0] b, input logic s,
                         input logic [2:0] res, input int lat_ee, input int lat_full,
                         input string name);
    vec_t v;
    v.a = a; v.b = b; v.s = s; v.res = res;
    v.lat_ee = lat_ee; v.lat_full = lat_full; v.name = name;
    vecs.push_back(v);
  endtask

  task automatic run_req(input vec_t v);
    int n;
    int exp_lat;
    exp_lat  = EE ? v.lat_ee : v.lat_full;
    check({v.name, " model_res"}, ref_res(v.a, v.b, v.s), v.res);
    check({v.name, " model_lat"}, ref_lat(v.a, v.b), exp_lat);
    i_a      = v.a;
    i_b      = v.b;
    i_signed = v.s;
    i_vld    = 1'b1;
    n = 0;
    while (!o_rdy && n < 20) begin
      @(posedge clk); #1; n++;
    end
    @(posedge clk); #1;
    i_vld = 1'b0;
    n = 0;
    while (!o_res_vld && n < 40) begin
      @(posedge clk); #1; n++;
    end
    check({v.name, " latency"}, n, exp_lat);
    check({v.name, " result"}, {o_eq, o_gt, o_lt}, v.res);
    i_res_rdy = 1'b1;
    @(posedge clk); #1;
    i_res_rdy = 1'b0;
    check({v.name, " rdy after consume"}, o_rdy, 1);
  endtask

  initial begin
    #200000;
    $display("FAIL global timeout");
    $fatal(1, "bench timeout");
  end

  initial begin
    int n;
    arst = 1'b1; i_vld = 1'b0; i_a = '0; i_b = '0; i_signed = 1'b0; i_res_rdy = 1'b0;
    #1;
    check("reset o_rdy", o_rdy, 1);
    check("reset o_res_vld", o_res_vld, 0);
    check("reset result", {o_eq, o_gt, o_lt}, 3'b000);
    repeat (2) @(posedge clk);
    #1 arst = 1'b0;
    check("post-reset o_rdy", o_rdy, 1);

    add_vec(32'hDEADBEEF, 32'hDEADBEEF, 1'b0, 3'b100, 4, 4, "eq_dead");
    add_vec(32'h80000000, 32'h7FFFFFFF, 1'b0, 3'b010, 1, 4, "msb_gt_u");
    add_vec(32'h80000000, 32'h7FFFFFFF, 1'b1, 3'b001, 1, 4, "msb_lt_s");
    add_vec(32'h00000001, 32'h00000002, 1'b0, 3'b001, 4, 4, "lsb_lt");
    add_vec(32'h01000002, 32'h01000001, 1'b0, 3'b010, 4, 4, "lsb_gt");
    add_vec(32'hFFFFFFFF, 32'h00000001, 1'b1, 3'b001, 1, 4, "neg_vs_pos");
    add_vec(32'hFFFFFFFF, 32'h00000001, 1'b0, 3'b010, 1, 4, "big_vs_one_u");
    add_vec(32'h12345678, 32'h12355678, 1'b0, 3'b001, 2, 4, "mid_lt");
    add_vec(32'hFFFFFFFE, 32'hFFFFFFFF, 1'b1, 3'b001, 4, 4, "neg_lsb_lt");
    add_vec(32'h80000000, 32'h80000000, 1'b1, 3'b100, 4, 4, "min_eq_s");
    foreach (vecs[i]) run_req(vecs[i]);

    // Backpressure: result held, new requests ignored while DONE.
    i_a = 32'd5; i_b = 32'd3; i_signed = 1'b0; i_vld = 1'b1;
    @(posedge clk); #1;
    i_vld = 1'b0;
    n = 0;
    while (!o_res_vld && n < 40) begin
      @(posedge clk); #1; n++;
    end
    check("bp result", {o_eq, o_gt, o_lt}, 3'b010);
    for (int k = 0; k < 5; k++) begin
      i_vld = k[0] ? 1'b0 : 1'b1;
      i_a   = 32'h100 + k;
      i_b   = 32'h900 - k;
      @(posedge clk); #1;
      check("bp o_rdy", o_rdy, 0);
      check("bp o_res_vld", o_res_vld, 1);
      check("bp held result", {o_eq, o_gt, o_lt}, 3'b010);
    end
    i_vld = 1'b0;
    i_res_rdy = 1'b1;
    @(posedge clk); #1;
    i_res_rdy = 1'b0;
    check("bp release o_rdy", o_rdy, 1);
    check("bp release o_res_vld", o_res_vld, 0);
    check("bp result kept", {o_eq, o_gt, o_lt}, 3'b010);
    repeat (6) begin
      @(posedge clk); #1;
      check("bp no ghost result", o_res_vld, 0);
    end

    // Reset mid-BUSY.
    i_a = 32'hDEADBEEF; i_b = 32'hDEADBEEF; i_signed = 1'b0; i_vld = 1'b1;
    @(posedge clk); #1;
    i_vld = 1'b0;
    check("rst busy o_rdy", o_rdy, 0);
    @(posedge clk);
    @(posedge clk); #1;
    arst = 1'b1;
    #1;
    check("rst o_res_vld", o_res_vld, 0);
    check("rst result", {o_eq, o_gt, o_lt}, 3'b000);
    check("rst o_rdy", o_rdy, 1);
    @(negedge clk); #1;
    arst = 1'b0;
    @(posedge clk); #1;
    check("after rst o_rdy", o_rdy, 1);
    repeat (6) begin
      @(posedge clk); #1;
      check("after rst no result", o_res_vld, 0);
    end

    run_req(vecs[1]);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
